// File: rtl/target_ring_fifo_if.sv
// Push/retire/read-port bundle for target_ring_fifo.
// master = record decoder / renderer side, slave = the ring buffer itself.
interface target_ring_fifo_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned TIME_W     = 8
);
    logic                  push_valid;
    logic [DATA_W-1:0]     push_data;
    logic                  push_ready;
    logic                  pop;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic [TIME_W-1:0]     cur_time;
    logic                  expired;

    modport master (
        output push_valid, push_data, pop, rd_idx, cur_time,
        input  push_ready, rd_data, rd_valid, count, full, empty, overflow, expired
    );

    modport slave (
        input  push_valid, push_data, pop, rd_idx, cur_time,
        output push_ready, rd_data, rd_valid, count, full, empty, overflow, expired
    );
endinterface

// File: rtl/target_ring_fifo.sv
// Circular buffer of on-screen target records with a registered random-access read port.
// Optional time-based auto-retire of the head entry: define TARGET_RING_AUTO_EXPIRE_EN.
module target_ring_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned TIME_W     = 8,
    parameter int unsigned TIME_LSB   = 3
) (
    input logic                 pxl_clk,
    input logic                 reset,
    target_ring_fifo_if.slave   bus
);
    localparam int unsigned            Depth    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    DepthCnt = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0]    CntOne   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0]  PtrOne   = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem_q [Depth];
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  expired_q, expired_d;

    logic                  full, empty;
    logic                  push_ok, retire, auto_ret;
    logic [DEPTH_LOG2-1:0] rd_addr;

    // Occupancy comes from the counter, so full and empty never alias on pointer equality.
    assign full    = (count_q == DepthCnt);
    assign empty   = (count_q == '0);
    assign push_ok = bus.push_valid && !full;
    assign retire  = (bus.pop || auto_ret) && !empty;
    assign rd_addr = head_q + bus.rd_idx;

`ifdef TARGET_RING_AUTO_EXPIRE_EN
    logic [TIME_W-1:0] head_time;
    logic [TIME_W-1:0] time_diff;

    assign head_time = mem_q[head_q][TIME_LSB +: TIME_W];
    assign time_diff = bus.cur_time - head_time;
    // Wrap-aware "deadline passed": difference non-zero and in the lower half of the time circle.
    assign auto_ret  = !empty && (time_diff != '0) && !time_diff[TIME_W-1];
`else
    logic unused_cur_time;

    assign auto_ret        = 1'b0;
    assign unused_cur_time = ^{bus.cur_time, 1'(TIME_LSB)};
`endif

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        expired_d  = 1'b0;

        if (retire) begin
            head_d    = head_q + PtrOne;
            expired_d = auto_ret;
        end
        if (push_ok) begin
            tail_d = tail_q + PtrOne;
        end
        if (bus.push_valid && full) begin
            overflow_d = 1'b1;
        end

        unique case ({push_ok, retire})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Read port samples the pre-update head and count.
    always_comb begin
        rd_data_d  = mem_q[rd_addr];
        rd_valid_d = ({1'b0, bus.rd_idx} < count_q);
    end

    always_ff @(posedge pxl_clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            expired_q  <= expired_d;
        end
    end

    // Storage is never cleared; writes are simply blocked while reset is held.
    always_ff @(posedge pxl_clk) begin
        if (push_ok && !reset) begin
            mem_q[tail_q] <= bus.push_data;
        end
    end

    assign bus.push_ready = !full;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.expired    = expired_q;

endmodule

// File: tb/tb_target_ring_fifo.sv
// Scoreboard bench for target_ring_fifo: a queue-based reference model predicts each cycle,
// a monitor process compares the DUT after every clock edge.
module tb_target_ring_fifo;
    localparam int unsigned DataW     = 32;
    localparam int unsigned DepthLog2 = 3;
    localparam int unsigned TimeW     = 8;
    localparam int unsigned TimeLsb   = 3;
    localparam int unsigned Depth     = 8;

    typedef struct {
        logic        rd_valid;
        logic [31:0] rd_data;
        int          count;
        logic        overflow;
        logic        expired;
    } exp_t;

    logic pxl_clk = 1'b0;
    logic reset   = 1'b1;

    exp_t        exp_q[$];
    logic [31:0] model_q[$];
    logic        model_ovf = 1'b0;
    int          checks    = 0;
    int          failures  = 0;

    always #5 pxl_clk = ~pxl_clk;

    target_ring_fifo_if #(.DATA_W(DataW), .DEPTH_LOG2(DepthLog2), .TIME_W(TimeW)) bus ();

    target_ring_fifo #(
        .DATA_W    (DataW),
        .DEPTH_LOG2(DepthLog2),
        .TIME_W    (TimeW),
        .TIME_LSB  (TimeLsb)
    ) dut (
        .pxl_clk(pxl_clk),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and predict the DUT state after the coming edge.
    task automatic step(input logic pv, input logic [31:0] pd, input logic pp, input int ri,
                        input logic [7:0] ct);
        exp_t e;
        int   sz;
        logic auto_r, ret, psh;
        @(negedge pxl_clk);
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop        = pp;
        bus.rd_idx     = 3'(ri);
        bus.cur_time   = ct;
        sz         = model_q.size();
        e.rd_valid = (ri < sz);
        e.rd_data  = e.rd_valid ? model_q[ri] : 32'h0;
        auto_r     = 1'b0;
`ifdef TARGET_RING_AUTO_EXPIRE_EN
        if (sz != 0) begin
            logic [31:0] hd;
            logic [7:0]  dt;
            hd     = model_q[0];
            dt     = ct - hd[TimeLsb +: TimeW];
            auto_r = (dt != 8'h0) && (dt < 8'h80);
        end
`endif
        ret = (pp || auto_r) && (sz != 0);
        psh = pv && (sz < Depth);
        if (pv && sz == Depth) model_ovf = 1'b1;
        if (ret) void'(model_q.pop_front());
        if (psh) model_q.push_back(pd);
        e.count    = model_q.size();
        e.overflow = model_ovf;
        e.expired  = ret && auto_r;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int ri);
        step(1'b0, 32'h0, 1'b0, ri, 8'h00);
    endtask

    task automatic chk_reset_state();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_expired", 32'(bus.expired), 32'd0);
        chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
    endtask

    // Async reset asserted mid-cycle, optionally with a push in flight.
    task automatic do_reset(input logic mid_push);
        @(negedge pxl_clk);
        bus.push_valid = mid_push;
        bus.push_data  = 32'hDEAD_BEEF;
        bus.pop        = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_state();
        @(negedge pxl_clk);
        bus.push_valid = 1'b0;
        reset          = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    // Monitor: compare whenever a prediction is pending, 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge pxl_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("count", 32'(bus.count), 32'(e.count));
                chk("full", 32'(bus.full), 32'(e.count == Depth));
                chk("empty", 32'(bus.empty), 32'(e.count == 0));
                chk("push_ready", 32'(bus.push_ready), 32'(e.count != Depth));
                chk("overflow", 32'(bus.overflow), 32'(e.overflow));
                chk("expired", 32'(bus.expired), 32'(e.expired));
                chk("rd_valid", 32'(bus.rd_valid), 32'(e.rd_valid));
                if (e.rd_valid) chk("rd_data", bus.rd_data, e.rd_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ct;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop        = 1'b0;
        bus.rd_idx     = '0;
        bus.cur_time   = '0;
        #3 chk_reset_state();
        @(negedge pxl_clk);
        reset = 1'b0;

        // Fill, then random-access read of slot 3.
        for (int i = 0; i < 8; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 0, 8'h00);
        idle(3);
        // Push while full is dropped and sets overflow.
        step(1'b1, 32'hBB, 1'b0, 7, 8'h00);
        for (int i = 0; i < 8; i++) idle(i);
        // Pop + push while full: only the pop lands; then the push wraps the tail.
        step(1'b1, 32'hCC, 1'b1, 0, 8'h00);
        step(1'b1, 32'hCC, 1'b0, 0, 8'h00);
        idle(7);
        // Drain, then pop + push on empty.
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 0, 8'h00);
        step(1'b1, 32'h11, 1'b1, 0, 8'h00);
        idle(0);
        idle(1);

        // Reset mid-sequence with five entries, then first push reads back at offset 0.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 0, 8'h00);
        idle(4);
        do_reset(1'b1);
        step(1'b1, 32'h55, 1'b0, 0, 8'h00);
        idle(0);
        idle(1);

`ifdef TARGET_RING_AUTO_EXPIRE_EN
        do_reset(1'b0);
        step(1'b1, 32'(8'hFE) << TimeLsb, 1'b0, 0, 8'hFE);
        step(1'b0, 32'h0, 1'b0, 0, 8'hFD);
        step(1'b0, 32'h0, 1'b0, 0, 8'hFE);
        step(1'b0, 32'h0, 1'b0, 0, 8'hFF);
        step(1'b0, 32'h0, 1'b0, 0, 8'hFF);
        step(1'b1, 32'(8'hFE) << TimeLsb, 1'b0, 0, 8'hFE);
        step(1'b0, 32'h0, 1'b1, 0, 8'h02);
        step(1'b0, 32'h0, 1'b0, 0, 8'h02);
`endif

        // Randomised phases alternating push-heavy and pop-heavy traffic.
        do_reset(1'b0);
        ct = 8'h00;
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 60; i++) begin
                int pv_pct;
                pv_pct = (ph % 2 == 0) ? 80 : 25;
                if ($urandom_range(0, 3) == 0) ct = ct + 8'd1;
                step($urandom_range(0, 99) < pv_pct, $urandom,
                     $urandom_range(0, 99) < (100 - pv_pct), $urandom_range(0, 7), ct);
            end
            if (ph == 3) do_reset(1'b1);
        end
        idle(0);
        @(negedge pxl_clk);
        @(negedge pxl_clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
